pingpong_ctrl: RTL and testbench
================================

Name: pingpong_ctrl

Overview:
Single-clock sequencer for the ping-pong input buffer that sits between the pixel/weight loader and the conv engine. It counts write beats into the fill bank and issues the bank-swap pulse once a frame is complete and the drain bank is free. It then streams read addresses to the conv engine under a valid/ready handshake. It replaces the free-running switch and static address drive with a frame-accurate schedule.

Parameters:
FRAME_DEPTH, 1024, beats per frame (one bank); legal range 2..2^ADDR_W
ADDR_W, 16, width of write/read address buses
FCNT_W, 8, width of completed-frame counter

Ports:
i_clk  input  1  system clock; all logic rising-edge
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  1 = controller runs; 0 = freeze all state (no swaps, no address advance)
i_data_din_vld  input  1  loader presents a beat this cycle
o_din_ready  output  1  fill bank can accept a beat
o_wr_addr  output  ADDR_W  write address for the fill bank
o_wr_en  output  1  = i_data_din_vld & o_din_ready & i_enable
o_switch_pingpong  output  1  one-cycle swap pulse to buffer
o_bank_sel  output  1  current fill bank (toggles on each swap)
o_conv_addr  output  ADDR_W  read address into the drain bank
o_rd_vld  output  1  o_conv_addr valid
i_conv_rdy  input  1  conv engine accepts current address
o_pl_buffer_ready  output  1  drain bank holds an unconsumed frame
o_frame_done  output  1  one-cycle pulse on last read beat accepted
o_frame_cnt  output  FCNT_W  completed drained frames, wraps modulo 2^FCNT_W
o_ovf_err  output  1  sticky: beat offered while o_din_ready=0

Behaviour:
Reset values:
- All outputs are 0 except o_din_ready=1.
- The write FSM is in WR_FILL and the read FSM is in RD_IDLE.
- Counters are 0, o_bank_sel=0, o_ovf_err=0.

Write FSM {WR_FILL, WR_FULL}:
- In WR_FILL, o_din_ready=1.
- Each o_wr_en beat writes at o_wr_addr, then o_wr_addr increments.
- On the beat with o_wr_addr==FRAME_DEPTH-1, the next state is WR_FULL and o_wr_addr holds.
- In WR_FULL, o_din_ready=0.

Read FSM {RD_IDLE, RD_RUN}:
- In RD_RUN, o_rd_vld=1.
- On o_rd_vld & i_conv_rdy, o_conv_addr increments.
- On the accept at FRAME_DEPTH-1:
  - next state is RD_IDLE;
  - o_conv_addr returns to 0;
  - o_frame_done pulses in the same cycle as that accept;
  - o_frame_cnt increments on the following edge.
- If i_conv_rdy=0, o_conv_addr and o_rd_vld hold (no drop, no skip).

Swap:
- o_switch_pingpong is a registered pulse, high for exactly one cycle.
- The pulse is asserted in the cycle after the registered condition (WR_FULL & RD_IDLE & i_enable) is true.
- On the swap edge:
  - write FSM goes to WR_FILL with o_wr_addr=0;
  - o_bank_sel toggles;
  - read FSM goes to RD_RUN with o_conv_addr=0;
  - o_pl_buffer_ready is set.
- Latency, last write beat (cycle N) to swap pulse: the pulse is high in cycle N+2, provided the drain side is already idle at N+1.
- o_din_ready is 0 during the pulse cycle.
- The first beat of the new frame is accepted at N+3.

o_pl_buffer_ready:
- Set on swap.
- Cleared on the edge after o_frame_done.

Simultaneous / boundary events:
- Last write beat and last read accept in the same cycle N: both FSMs reach their wait states at N+1 and the swap pulse is at N+2 (same as above, no extra bubble).
- Write completes while read still running: stay in WR_FULL and hold o_din_ready=0 until read reaches RD_IDLE, then swap per the rule above.
- Read finishes with no full write frame: RD_IDLE is held and o_rd_vld=0; no swap occurs.
- i_data_din_vld=1 while o_din_ready=0: the beat is dropped, no write occurs, and o_ovf_err is set until reset.
- i_enable=0: all registers hold and pulses are suppressed; o_wr_en=0 and o_rd_vld=0 while disabled. A pending swap fires on the second enabled cycle.
- Reset mid-frame (async) forces all reset values immediately. A partially written frame is discarded.
- o_frame_cnt wraps from 2^FCNT_W-1 to 0.

Test Plan:
1. Reset, FRAME_DEPTH=8, i_conv_rdy=1, i_data_din_vld=1 continuous.
   - Required: o_wr_addr runs 0..7, then o_din_ready=0.
   - Required: swap pulse 2 cycles after beat 7, then o_bank_sel=1 and o_conv_addr runs 0..7.
   - Required: o_frame_done at addr 7, then o_frame_cnt=1.
2. Steady stream with i_conv_rdy=1 → each frame reads in 8 cycles and writes in 8 cycles, with a 2-cycle swap gap. After 4 frames, o_bank_sel=0 and o_frame_cnt=3.
3. i_conv_rdy toggling 1/0, write completes first → write stalls in WR_FULL. Required: no address skipped or repeated on the read side, swap only after o_frame_done, and o_ovf_err stays 0 while the loader honours o_din_ready.
4. i_data_din_vld held 1 while in WR_FULL → o_ovf_err=1 (sticky), o_wr_addr unchanged, no o_wr_en.
5. Assert i_rst_n=0 at write beat 5 and read beat 3 → immediate reset values: o_wr_addr=0, o_conv_addr=0, o_rd_vld=0, o_pl_buffer_ready=0, o_din_ready=1.
6. i_enable=0 for 3 cycles while a swap is pending → no pulse while disabled; the pulse occurs on the 2nd cycle after i_enable returns to 1. o_frame_cnt wrap check with FCNT_W=2: 4 frames → 0.

Source files
------------

// File: rtl/pingpong_ctrl.sv
// Ping-pong input buffer sequencer: counts loader beats into the fill bank, swaps banks
// once a frame is complete and the drain bank is idle, then streams read addresses out.
module pingpong_ctrl #(
    parameter int FRAME_DEPTH = 1024,
    parameter int ADDR_W      = 16,
    parameter int FCNT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_data_din_vld,
    output logic              o_din_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_en,
    output logic              o_switch_pingpong,
    output logic              o_bank_sel,
    output logic [ADDR_W-1:0] o_conv_addr,
    output logic              o_rd_vld,
    input  logic              i_conv_rdy,
    output logic              o_pl_buffer_ready,
    output logic              o_frame_done,
    output logic [FCNT_W-1:0] o_frame_cnt,
    output logic              o_ovf_err
);

    typedef enum logic {WR_FILL = 1'b0, WR_FULL = 1'b1} wr_state_t;
    typedef enum logic {RD_IDLE = 1'b0, RD_RUN  = 1'b1} rd_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    function automatic logic is_last(input logic [ADDR_W-1:0] addr);
        return (addr == LAST_ADDR);
    endfunction

    wr_state_t         wr_state_r, wr_state_s;
    rd_state_t         rd_state_r, rd_state_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [ADDR_W-1:0] conv_addr_r, conv_addr_s;
    logic              swap_r, swap_s;
    logic              bank_sel_r, bank_sel_s;
    logic              buf_ready_r, buf_ready_s;
    logic [FCNT_W-1:0] frame_cnt_r, frame_cnt_s;
    logic              ovf_err_r, ovf_err_s;

    logic din_ready_s;
    logic wr_en_s;
    logic rd_vld_s;
    logic rd_acc_s;
    logic frame_done_s;
    logic swap_go_s;

    // Handshake decode, next-state logic for both FSMs and the swap scheduler
    always_comb begin
        wr_state_s   = wr_state_r;
        rd_state_s   = rd_state_r;
        wr_addr_s    = wr_addr_r;
        conv_addr_s  = conv_addr_r;
        bank_sel_s   = bank_sel_r;
        buf_ready_s  = buf_ready_r;
        frame_cnt_s  = frame_cnt_r;
        ovf_err_s    = ovf_err_r;

        din_ready_s  = (wr_state_r == WR_FILL);
        wr_en_s      = i_data_din_vld & din_ready_s & i_enable;
        rd_vld_s     = (rd_state_r == RD_RUN) & i_enable;
        rd_acc_s     = rd_vld_s & i_conv_rdy;
        frame_done_s = rd_acc_s & is_last(conv_addr_r);
        // The swap fires at the end of the pulse cycle; a pulse that lands while
        // disabled is dropped and the swap condition is simply re-evaluated.
        swap_go_s    = swap_r & i_enable;
        swap_s       = (wr_state_r == WR_FULL) & (rd_state_r == RD_IDLE)
                       & i_enable & ~swap_r;

        case (wr_state_r)
            WR_FILL: begin
                if (wr_en_s) begin
                    if (is_last(wr_addr_r)) begin
                        wr_state_s = WR_FULL;
                    end else begin
                        wr_addr_s = wr_addr_r + ADDR_W'(1);
                    end
                end else begin
                    wr_addr_s = wr_addr_r;
                end
            end
            WR_FULL: begin
                if (swap_go_s) begin
                    wr_state_s = WR_FILL;
                    wr_addr_s  = ZERO_ADDR;
                end else begin
                    wr_state_s = WR_FULL;
                end
            end
            default: begin
                wr_state_s = WR_FILL;
                wr_addr_s  = ZERO_ADDR;
            end
        endcase

        case (rd_state_r)
            RD_IDLE: begin
                if (swap_go_s) begin
                    rd_state_s  = RD_RUN;
                    conv_addr_s = ZERO_ADDR;
                end else begin
                    rd_state_s  = RD_IDLE;
                end
            end
            RD_RUN: begin
                if (rd_acc_s) begin
                    if (is_last(conv_addr_r)) begin
                        rd_state_s  = RD_IDLE;
                        conv_addr_s = ZERO_ADDR;
                    end else begin
                        conv_addr_s = conv_addr_r + ADDR_W'(1);
                    end
                end else begin
                    conv_addr_s = conv_addr_r;
                end
            end
            default: begin
                rd_state_s  = RD_IDLE;
                conv_addr_s = ZERO_ADDR;
            end
        endcase

        if (swap_go_s) begin
            bank_sel_s  = ~bank_sel_r;
            buf_ready_s = 1'b1;
        end else if (frame_done_s) begin
            buf_ready_s = 1'b0;
        end else begin
            buf_ready_s = buf_ready_r;
        end

        if (frame_done_s) begin
            frame_cnt_s = frame_cnt_r + FCNT_W'(1);
        end else begin
            frame_cnt_s = frame_cnt_r;
        end

        if (i_data_din_vld & ~din_ready_s & i_enable) begin
            ovf_err_s = 1'b1;
        end else begin
            ovf_err_s = ovf_err_r;
        end
    end

    // State and counter registers; asynchronous reset discards any partial frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_state_r  <= WR_FILL;
            rd_state_r  <= RD_IDLE;
            wr_addr_r   <= ZERO_ADDR;
            conv_addr_r <= ZERO_ADDR;
            swap_r      <= 1'b0;
            bank_sel_r  <= 1'b0;
            buf_ready_r <= 1'b0;
            frame_cnt_r <= {FCNT_W{1'b0}};
            ovf_err_r   <= 1'b0;
        end else if (i_enable) begin
            wr_state_r  <= wr_state_s;
            rd_state_r  <= rd_state_s;
            wr_addr_r   <= wr_addr_s;
            conv_addr_r <= conv_addr_s;
            swap_r      <= swap_s;
            bank_sel_r  <= bank_sel_s;
            buf_ready_r <= buf_ready_s;
            frame_cnt_r <= frame_cnt_s;
            ovf_err_r   <= ovf_err_s;
        end else begin
            swap_r      <= 1'b0;
        end
    end

    assign o_din_ready       = din_ready_s;
    assign o_wr_addr         = wr_addr_r;
    assign o_wr_en           = wr_en_s;
    assign o_switch_pingpong = swap_go_s;
    assign o_bank_sel        = bank_sel_r;
    assign o_conv_addr       = conv_addr_r;
    assign o_rd_vld          = rd_vld_s;
    assign o_pl_buffer_ready = buf_ready_r;
    assign o_frame_done      = frame_done_s;
    assign o_frame_cnt       = frame_cnt_r;
    assign o_ovf_err         = ovf_err_r;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl (FRAME_DEPTH=8, FCNT_W=2): directed vector table, hand sequences
// for swap/enable/reset corners, and random traffic checked against a frame-level model.
module tb_pingpong_ctrl;
    localparam int FD = 8;
    localparam int AW = 16;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          vld = 1'b0;
    logic          rdy = 1'b0;
    logic          din_ready, wr_en, sw, bank, rd_vld, bufrdy, fdone, ovf;
    logic [AW-1:0] wr_addr, conv_addr;
    logic [FW-1:0] fcnt;

    pingpong_ctrl #(.FRAME_DEPTH(FD), .ADDR_W(AW), .FCNT_W(FW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_data_din_vld(vld),
        .o_din_ready(din_ready), .o_wr_addr(wr_addr), .o_wr_en(wr_en),
        .o_switch_pingpong(sw), .o_bank_sel(bank), .o_conv_addr(conv_addr),
        .o_rd_vld(rd_vld), .i_conv_rdy(rdy), .o_pl_buffer_ready(bufrdy),
        .o_frame_done(fdone), .o_frame_cnt(fcnt), .o_ovf_err(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: beats held in the fill bank, drain position, pending pulse.
    int m_filled, m_idx, m_frames;
    bit m_drain, m_bank, m_pend, m_ovf, m_bufrdy;

    task automatic model_reset();
        m_filled = 0; m_idx = 0; m_frames = 0;
        m_drain = 0; m_bank = 0; m_pend = 0; m_ovf = 0; m_bufrdy = 0;
    endtask

    task automatic check_model();
        bit e_dr;
        e_dr = (m_filled < FD);
        chk1("m_din_ready", din_ready, e_dr);
        chkn("m_wr_addr", int'(wr_addr), (m_filled == FD) ? FD - 1 : m_filled);
        chk1("m_wr_en", wr_en, vld & e_dr & en);
        chk1("m_switch", sw, m_pend & en);
        chk1("m_bank", bank, m_bank);
        chkn("m_conv_addr", int'(conv_addr), m_idx);
        chk1("m_rd_vld", rd_vld, m_drain & en);
        chk1("m_frame_done", fdone, m_drain & en & rdy & (m_idx == FD - 1));
        chkn("m_frame_cnt", int'(fcnt), m_frames % (1 << FW));
        chk1("m_ovf", ovf, m_ovf);
        chk1("m_bufrdy", bufrdy, m_bufrdy);
    endtask

    task automatic model_tick();
        bit swp, dr, cond;
        if (en) begin
            swp  = m_pend;
            dr   = (m_filled < FD);
            cond = (m_filled == FD) && !m_drain && !swp;
            if (vld && !dr) m_ovf = 1;
            if (swp) begin
                m_filled = 0; m_bank = ~m_bank; m_drain = 1; m_idx = 0; m_bufrdy = 1;
            end else begin
                if (vld && dr) m_filled++;
                if (m_drain && rdy) begin
                    if (m_idx == FD - 1) begin
                        m_drain = 0; m_idx = 0; m_frames++; m_bufrdy = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            m_pend = cond;
        end else begin
            m_pend = 0;
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic e);
        @(negedge clk);
        vld = v; rdy = r; en = e;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    task automatic do_reset();
        #1;
        vld = 1'b0; rdy = 1'b0; en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rst_din_ready", din_ready, 1'b1);
        chkn("rst_wr_addr", int'(wr_addr), 0);
        chkn("rst_conv_addr", int'(conv_addr), 0);
        chk1("rst_rd_vld", rd_vld, 1'b0);
        chk1("rst_bufrdy", bufrdy, 1'b0);
        chk1("rst_bank", bank, 1'b0);
        chk1("rst_switch", sw, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        chkn("rst_frame_cnt", int'(fcnt), 0);
        chk1("rst_wr_en", wr_en, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v, r, e;
        int   wa;
        logic dr, we, sw, bs;
        int   ca;
        logic rv, fd;
        int   fc;
    } vec_t;

    function automatic vec_t mk(int wa, logic dr, logic we, logic s, logic bs,
                                int ca, logic rv, logic fd, int fc);
        vec_t t;
        t.v = 1'b1; t.r = 1'b1; t.e = 1'b1;
        t.wa = wa; t.dr = dr; t.we = we; t.sw = s; t.bs = bs;
        t.ca = ca; t.rv = rv; t.fd = fd; t.fc = fc;
        return t;
    endfunction

    vec_t tbl[20];

    initial begin
        int pulses, last_p, cnt;
        bit got;

        // Continuous stream from reset: fill 0..7, swap gap, drain 0..7 while refilling.
        for (int c = 0; c < 8; c++) tbl[c] = mk(c, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[8] = mk(7, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9] = mk(7, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int c = 10; c < 18; c++) tbl[c] = mk(c - 10, 1, 1, 0, 1, c - 10, 1, c == 17, 0);
        tbl[18] = mk(7, 0, 0, 0, 1, 0, 0, 0, 1);
        tbl[19] = mk(7, 0, 0, 1, 1, 0, 0, 0, 1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].e);
            chkn("t_wr_addr", int'(wr_addr), tbl[i].wa);
            chk1("t_din_ready", din_ready, tbl[i].dr);
            chk1("t_wr_en", wr_en, tbl[i].we);
            chk1("t_switch", sw, tbl[i].sw);
            chk1("t_bank", bank, tbl[i].bs);
            chkn("t_conv_addr", int'(conv_addr), tbl[i].ca);
            chk1("t_rd_vld", rd_vld, tbl[i].rv);
            chk1("t_frame_done", fdone, tbl[i].fd);
            chkn("t_frame_cnt", int'(fcnt), tbl[i].fc);
            tick();
        end

        // Steady stream: 10-cycle swap period, bank/count after 4 swaps, then count wrap.
        do_reset();
        pulses = 0; last_p = -1;
        for (int c = 0; c < 80 && pulses < 4; c++) begin
            drive(1, 1, 1);
            if (sw) begin
                if (pulses > 0) chkn("swap_spacing", c - last_p, 10);
                last_p = c;
                pulses++;
            end
            tick();
        end
        chkn("swap_count", pulses, 4);
        drive(1, 1, 1);
        chk1("bank_after4", bank, 1'b0);
        chkn("fcnt_after4", int'(fcnt), 3);
        tick();
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            drive(1, 1, 1);
            if (fdone) got = 1;
            tick();
        end
        chk1("fourth_done_seen", got, 1'b1);
        drive(1, 1, 1);
        chkn("fcnt_wrap", int'(fcnt), 0);
        tick();

        // Reset in the middle of write beat 5 / read beat 3.
        do_reset();
        for (int c = 0; c < 13; c++) begin drive(1, 1, 1); tick(); end
        for (int c = 0; c < 2; c++) begin drive(1, 0, 1); tick(); end
        drive(1, 0, 1);
        chkn("pre_rst_wr_addr", int'(wr_addr), 5);
        chkn("pre_rst_conv_addr", int'(conv_addr), 3);
        do_reset();

        // Pending swap across a 3-cycle disable: pulse on the 2nd enabled cycle.
        do_reset();
        for (int c = 0; c < 8; c++) begin drive(1, 1, 1); tick(); end
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0);
            chk1("dis_switch", sw, 1'b0);
            chk1("dis_wr_en", wr_en, 1'b0);
            tick();
        end
        drive(0, 1, 1);
        chk1("en1_switch", sw, 1'b0);
        tick();
        drive(0, 1, 1);
        chk1("en2_switch", sw, 1'b1);
        chk1("en2_din_ready", din_ready, 1'b0);
        tick();
        drive(0, 1, 1);
        chk1("post_swap_bank", bank, 1'b1);
        chk1("post_swap_bufrdy", bufrdy, 1'b1);
        tick();

        // Overflow: offer beats while the fill bank is full and the reader is stalled.
        do_reset();
        for (int c = 0; c < 18; c++) begin drive(1, 0, 1); tick(); end
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 1);
            chk1("ovf_wr_en", wr_en, 1'b0);
            chkn("ovf_wr_addr", int'(wr_addr), 7);
            tick();
        end
        for (int c = 0; c < 3; c++) begin drive(0, 0, 1); tick(); end
        drive(0, 0, 1);
        chk1("ovf_sticky", ovf, 1'b1);
        tick();

        // Toggling reader, loader honours ready: writer stalls, reads stay in order.
        do_reset();
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            drive((m_filled < FD) && ($urandom_range(3) != 0), c[0], 1);
            if (sw) chk1("swap_while_draining", rd_vld, 1'b0);
            if (fdone) cnt++;
            tick();
        end
        chk1("honour_no_ovf", ovf, 1'b0);
        chk1("honour_progress", cnt > 3, 1'b1);

        // Unconstrained random traffic, including disables and one mid-run reset.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) do_reset();
            drive(($urandom_range(3) != 0), ($urandom_range(2) != 0), ($urandom_range(7) != 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
